// File: rtl/avg_threshold_detector.sv
// avg_threshold_detector: hysteresis threshold detector with debounce that
// sits after the moving-average stage. It reports rise/fall crossings, counts
// rising crossings with saturation, captures the peak of each completed high
// excursion, and forwards the sample stream one cycle delayed.
module avg_threshold_detector #(
    parameter int CNT_W    = 16,
    parameter int DEBOUNCE = 2
) (
    input  logic             clk,
    input  logic             RST,
    input  logic [31:0]      data_in,
    input  logic             e_in,
    input  logic [31:0]      th_hi,
    input  logic [31:0]      th_lo,
    input  logic             clr,
    output logic [31:0]      data_out,
    output logic             e_out,
    output logic             level,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] cross_cnt,
    output logic [31:0]      peak,
    output logic             peak_valid
);

    typedef enum logic [1:0] {
        S_LOW       = 2'd0,
        S_RISE_PEND = 2'd1,
        S_HIGH      = 2'd2,
        S_FALL_PEND = 2'd3
    } state_t;

    // Debounce lengths run 1..15, so four bits of count always suffice.
    localparam logic [3:0] DEB = 4'(DEBOUNCE);

    state_t            state, state_nxt;
    logic [3:0]        dcnt, dcnt_nxt;
    logic [31:0]       run_max, run_max_nxt;
    logic [31:0]       th_lo_eff;
    logic              hi_hit, lo_hit;
    logic              rise_nxt, fall_nxt;
    logic [CNT_W-1:0]  cnt_base, cnt_nxt;

    function automatic logic [31:0] max_u32(input logic [31:0] a, input logic [31:0] b);
        return (a >= b) ? a : b;
    endfunction

    // Threshold compare and FSM next-state; invalid cycles leave everything as is.
    always_comb begin
        th_lo_eff   = (th_lo <= th_hi) ? th_lo : th_hi;
        hi_hit      = (data_in >= th_hi);
        lo_hit      = (data_in < th_lo_eff);
        state_nxt   = state;
        dcnt_nxt    = dcnt;
        run_max_nxt = run_max;
        rise_nxt    = 1'b0;
        fall_nxt    = 1'b0;
        if (e_in) begin
            case (state)
                S_LOW: begin
                    if (hi_hit) begin
                        if (DEB == 4'd1) begin
                            state_nxt   = S_HIGH;
                            rise_nxt    = 1'b1;
                            run_max_nxt = data_in;
                            dcnt_nxt    = 4'd0;
                        end else begin
                            state_nxt = S_RISE_PEND;
                            dcnt_nxt  = 4'd1;
                        end
                    end
                end
                S_RISE_PEND: begin
                    if (hi_hit) begin
                        if (dcnt + 4'd1 == DEB) begin
                            state_nxt   = S_HIGH;
                            rise_nxt    = 1'b1;
                            run_max_nxt = data_in;
                            dcnt_nxt    = 4'd0;
                        end else begin
                            dcnt_nxt = dcnt + 4'd1;
                        end
                    end else begin
                        state_nxt = S_LOW;
                        dcnt_nxt  = 4'd0;
                    end
                end
                S_HIGH: begin
                    run_max_nxt = max_u32(run_max, data_in);
                    if (lo_hit) begin
                        if (DEB == 4'd1) begin
                            state_nxt = S_LOW;
                            fall_nxt  = 1'b1;
                            dcnt_nxt  = 4'd0;
                        end else begin
                            state_nxt = S_FALL_PEND;
                            dcnt_nxt  = 4'd1;
                        end
                    end
                end
                S_FALL_PEND: begin
                    run_max_nxt = max_u32(run_max, data_in);
                    if (lo_hit) begin
                        if (dcnt + 4'd1 == DEB) begin
                            state_nxt = S_LOW;
                            fall_nxt  = 1'b1;
                            dcnt_nxt  = 4'd0;
                        end else begin
                            dcnt_nxt = dcnt + 4'd1;
                        end
                    end else begin
                        state_nxt = S_HIGH;
                        dcnt_nxt  = 4'd0;
                    end
                end
                default: begin
                    state_nxt = S_LOW;
                    dcnt_nxt  = 4'd0;
                end
            endcase
        end
    end

    // Crossing counter: clr is applied first, then a same-cycle rise increments with saturation.
    always_comb begin
        cnt_base = clr ? '0 : cross_cnt;
        cnt_nxt  = cnt_base;
        if (rise_nxt && (cnt_base != {CNT_W{1'b1}})) begin
            cnt_nxt = cnt_base + 1'b1;
        end
    end

    // FSM state, debounce count and running max.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state   <= S_LOW;
            dcnt    <= 4'd0;
            run_max <= 32'd0;
        end else begin
            state   <= state_nxt;
            dcnt    <= dcnt_nxt;
            run_max <= run_max_nxt;
        end
    end

    // Registered outputs; a completed excursion outranks a same-cycle clr for peak.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            data_out   <= 32'd0;
            e_out      <= 1'b0;
            level      <= 1'b0;
            rise       <= 1'b0;
            fall       <= 1'b0;
            cross_cnt  <= '0;
            peak       <= 32'd0;
            peak_valid <= 1'b0;
        end else begin
            if (e_in) begin
                data_out <= data_in;
            end
            e_out     <= e_in;
            level     <= (state_nxt == S_HIGH) || (state_nxt == S_FALL_PEND);
            rise      <= rise_nxt;
            fall      <= fall_nxt;
            cross_cnt <= cnt_nxt;
            if (fall_nxt) begin
                peak       <= run_max_nxt;
                peak_valid <= 1'b1;
            end else if (clr) begin
                peak       <= 32'd0;
                peak_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_avg_threshold_detector.sv
// Directed testbench for avg_threshold_detector (CNT_W=4, DEBOUNCE=2).
module tb_avg_threshold_detector;

    logic        clk = 1'b0;
    logic        RST;
    logic [31:0] data_in;
    logic        e_in;
    logic [31:0] th_hi;
    logic [31:0] th_lo;
    logic        clr;
    logic [31:0] data_out;
    logic        e_out;
    logic        level;
    logic        rise;
    logic        fall;
    logic [3:0]  cross_cnt;
    logic [31:0] peak;
    logic        peak_valid;

    int tests = 0;
    int fails = 0;

    avg_threshold_detector #(.CNT_W(4), .DEBOUNCE(2)) dut (
        .clk        (clk),
        .RST        (RST),
        .data_in    (data_in),
        .e_in       (e_in),
        .th_hi      (th_hi),
        .th_lo      (th_lo),
        .clr        (clr),
        .data_out   (data_out),
        .e_out      (e_out),
        .level      (level),
        .rise       (rise),
        .fall       (fall),
        .cross_cnt  (cross_cnt),
        .peak       (peak),
        .peak_valid (peak_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs on the falling edge, then settle past the rising edge.
    task automatic step(input logic [31:0] d, input logic e, input logic c);
        @(negedge clk);
        data_in = d;
        e_in    = e;
        clr     = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        RST     = 1'b1;
        e_in    = 1'b0;
        clr     = 1'b0;
        data_in = 32'd0;
        @(negedge clk);
        RST = 1'b0;
    endtask

    initial begin
        RST     = 1'b1;
        data_in = 32'd0;
        e_in    = 1'b0;
        clr     = 1'b0;
        th_hi   = 32'd100;
        th_lo   = 32'd50;
        repeat (2) @(posedge clk);
        #1;
        check("rst_level", {31'd0, level}, 32'd0);
        check("rst_cnt", {28'd0, cross_cnt}, 32'd0);
        check("rst_peak", peak, 32'd0);
        check("rst_pv", {31'd0, peak_valid}, 32'd0);
        check("rst_dout", data_out, 32'd0);
        @(negedge clk);
        RST = 1'b0;

        // Idle samples below threshold; stream forwarding.
        step(32'd10, 1'b1, 1'b0);
        check("idle_dout10", data_out, 32'd10);
        check("idle_eout1", {31'd0, e_out}, 32'd1);
        check("idle_level", {31'd0, level}, 32'd0);
        step(32'd20, 1'b1, 1'b0);
        check("idle_dout20", data_out, 32'd20);
        check("idle_rise", {31'd0, rise}, 32'd0);
        step(32'd77, 1'b0, 1'b0);
        check("idle_eout0", {31'd0, e_out}, 32'd0);
        check("idle_dout_hold", data_out, 32'd20);

        // Debounced rise and fall.
        step(32'd120, 1'b1, 1'b0);
        check("r1_rise_early", {31'd0, rise}, 32'd0);
        check("r1_level_early", {31'd0, level}, 32'd0);
        step(32'd130, 1'b1, 1'b0);
        check("r1_rise", {31'd0, rise}, 32'd1);
        check("r1_level", {31'd0, level}, 32'd1);
        check("r1_cnt", {28'd0, cross_cnt}, 32'd1);
        step(32'd90, 1'b1, 1'b0);
        check("r1_rise_pulse", {31'd0, rise}, 32'd0);
        step(32'd40, 1'b1, 1'b0);
        check("f1_fall_early", {31'd0, fall}, 32'd0);
        check("f1_level_pend", {31'd0, level}, 32'd1);
        step(32'd30, 1'b1, 1'b0);
        check("f1_fall", {31'd0, fall}, 32'd1);
        check("f1_peak", peak, 32'd130);
        check("f1_pv", {31'd0, peak_valid}, 32'd1);
        check("f1_level", {31'd0, level}, 32'd0);
        step(32'd0, 1'b0, 1'b0);
        check("f1_fall_pulse", {31'd0, fall}, 32'd0);

        // Reset in the middle of an excursion aborts it.
        step(32'd150, 1'b1, 1'b0);
        step(32'd150, 1'b1, 1'b0);
        check("ab_level", {31'd0, level}, 32'd1);
        @(negedge clk);
        RST = 1'b1;
        #1;
        check("ab_pv", {31'd0, peak_valid}, 32'd0);
        check("ab_level_rst", {31'd0, level}, 32'd0);
        check("ab_cnt", {28'd0, cross_cnt}, 32'd0);
        @(negedge clk);
        RST = 1'b0;
        step(32'd10, 1'b1, 1'b0);
        check("ab_no_fall", {31'd0, fall}, 32'd0);

        // Glitch rejection.
        do_reset();
        step(32'd120, 1'b1, 1'b0); check("gl_rise_a", {31'd0, rise}, 32'd0);
        step(32'd80, 1'b1, 1'b0);  check("gl_rise_b", {31'd0, rise}, 32'd0);
        step(32'd120, 1'b1, 1'b0); check("gl_rise_c", {31'd0, rise}, 32'd0);
        step(32'd45, 1'b1, 1'b0);  check("gl_rise_d", {31'd0, rise}, 32'd0);
        step(32'd70, 1'b1, 1'b0);  check("gl_rise_e", {31'd0, rise}, 32'd0);
        check("gl_cnt0", {28'd0, cross_cnt}, 32'd0);
        step(32'd120, 1'b1, 1'b0);
        step(32'd125, 1'b1, 1'b0);
        check("gl_rise", {31'd0, rise}, 32'd1);
        check("gl_cnt1", {28'd0, cross_cnt}, 32'd1);
        step(32'd40, 1'b1, 1'b0);  check("gl_fall_a", {31'd0, fall}, 32'd0);
        step(32'd60, 1'b1, 1'b0);  check("gl_fall_b", {31'd0, fall}, 32'd0);
        check("gl_level_hold", {31'd0, level}, 32'd1);
        step(32'd40, 1'b1, 1'b0);  check("gl_fall_c", {31'd0, fall}, 32'd0);
        check("gl_level_pend", {31'd0, level}, 32'd1);

        // Invalid cycles neither break nor advance the debounce.
        do_reset();
        step(32'd120, 1'b1, 1'b0);
        check("gap_rise0", {31'd0, rise}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(32'd0, 1'b0, 1'b0);
            check("gap_idle_rise", {31'd0, rise}, 32'd0);
            check("gap_idle_level", {31'd0, level}, 32'd0);
        end
        step(32'd110, 1'b1, 1'b0);
        check("gap_rise", {31'd0, rise}, 32'd1);
        check("gap_dout", data_out, 32'd110);

        // Degenerate thresholds: th_lo above th_hi collapses to th_hi.
        do_reset();
        th_hi = 32'd100;
        th_lo = 32'd200;
        step(32'd100, 1'b1, 1'b0);
        step(32'd100, 1'b1, 1'b0);
        check("dg_rise", {31'd0, rise}, 32'd1);
        step(32'd99, 1'b1, 1'b0);
        check("dg_fall_early", {31'd0, fall}, 32'd0);
        step(32'd99, 1'b1, 1'b0);
        check("dg_fall", {31'd0, fall}, 32'd1);
        check("dg_peak", peak, 32'd100);
        step(32'd100, 1'b1, 1'b0);
        step(32'd100, 1'b1, 1'b0);
        step(32'd150, 1'b1, 1'b0);
        step(32'd150, 1'b1, 1'b0);
        check("dg_mid_level", {31'd0, level}, 32'd1);
        check("dg_mid_fall", {31'd0, fall}, 32'd0);
        step(32'd99, 1'b1, 1'b0);
        step(32'd99, 1'b1, 1'b0);
        check("dg_fall2", {31'd0, fall}, 32'd1);
        check("dg_peak2", peak, 32'd150);
        th_lo = 32'd50;

        // Counter saturation, then clr coinciding with rise and with fall.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(32'd120, 1'b1, 1'b0);
            step(32'd120, 1'b1, 1'b0);
            check("sat_cnt", {28'd0, cross_cnt}, (i < 15) ? 32'(i + 1) : 32'd15);
            step(32'd30, 1'b1, 1'b0);
            step(32'd30, 1'b1, 1'b0);
        end
        check("sat_peak", peak, 32'd120);
        check("sat_pv", {31'd0, peak_valid}, 32'd1);
        step(32'd120, 1'b1, 1'b0);
        step(32'd140, 1'b1, 1'b1);
        check("clr_rise", {31'd0, rise}, 32'd1);
        check("clr_rise_cnt", {28'd0, cross_cnt}, 32'd1);
        check("clr_rise_pv", {31'd0, peak_valid}, 32'd0);
        check("clr_rise_level", {31'd0, level}, 32'd1);
        step(32'd30, 1'b1, 1'b0);
        step(32'd30, 1'b1, 1'b1);
        check("clr_fall", {31'd0, fall}, 32'd1);
        check("clr_fall_peak", peak, 32'd140);
        check("clr_fall_pv", {31'd0, peak_valid}, 32'd1);
        check("clr_fall_cnt", {28'd0, cross_cnt}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
